// File: rtl/steering_ramp_controller.sv
// Slew-limited duty/direction sequencer for the H-bridge steering driver.
// Reversals brake to zero and hold there for a dead time before the direction flips.
module steering_ramp_controller #(
  parameter int COUNT_SIZE  = 4,
  parameter int STEP        = 1,
  parameter int TICK_DIV    = 1024,
  parameter int DEAD_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cmd_in,
  input  logic        cmd_valid,
  output logic [31:0] steer_word,
  output logic        busy,
  output logic        at_target
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DEAD_CYCLES + 1);
  localparam logic [COUNT_SIZE:0] STEP_W = (COUNT_SIZE+1)'(STEP);

  typedef enum logic [1:0] {HOLD, RAMP, BRAKE, DEAD} state_t;

  state_t                state, state_nxt;
  logic [COUNT_SIZE-1:0] duty, duty_nxt, tgt_duty;
  logic                  dir, dir_nxt, tgt_dir, clr;
  logic [PW-1:0]         presc;
  logic [DW-1:0]         dead_cnt, dead_nxt;
  logic                  tick, soft_clr;
  logic [COUNT_SIZE:0]   up_gap, dn_gap;
  logic                  unused_cmd;

  assign unused_cmd = ^cmd_in[29:COUNT_SIZE];
  assign tick       = (presc == PW'(TICK_DIV - 1));
  assign soft_clr   = cmd_valid & cmd_in[31];
  assign up_gap     = {1'b0, tgt_duty} - {1'b0, duty};
  assign dn_gap     = {1'b0, duty} - {1'b0, tgt_duty};

  // The state is re-derived every clock from the registered targets, so a
  // new target or a tick landing on a state entry is handled by the new state.
  always_comb begin
    state_nxt = HOLD;
    duty_nxt  = duty;
    dir_nxt   = dir;
    dead_nxt  = '0;
    if (dir != tgt_dir)       state_nxt = (duty != '0) ? BRAKE : DEAD;
    else if (duty != tgt_duty) state_nxt = RAMP;
    unique case (state_nxt)
      RAMP: begin
        if (tick && (duty < tgt_duty))
          duty_nxt = (up_gap <= STEP_W) ? tgt_duty : duty + STEP_W[COUNT_SIZE-1:0];
        else if (tick)
          duty_nxt = (dn_gap <= STEP_W) ? tgt_duty : duty - STEP_W[COUNT_SIZE-1:0];
      end
      BRAKE: begin
        if (tick)
          duty_nxt = ({1'b0, duty} <= STEP_W) ? '0 : duty - STEP_W[COUNT_SIZE-1:0];
      end
      DEAD: begin
        // Direction may only flip after duty has sat at zero for the full count.
        if (dead_cnt == DW'(DEAD_CYCLES - 1)) dir_nxt  = tgt_dir;
        else                                  dead_nxt = dead_cnt + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= HOLD;
      duty     <= '0;
      dir      <= 1'b0;
      tgt_duty <= '0;
      tgt_dir  <= 1'b0;
      presc    <= '0;
      dead_cnt <= '0;
      clr      <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (soft_clr) begin
        state    <= HOLD;
        duty     <= '0;
        tgt_duty <= '0;
        dead_cnt <= '0;
        clr      <= 1'b1;
      end else begin
        state    <= state_nxt;
        duty     <= duty_nxt;
        dir      <= dir_nxt;
        dead_cnt <= dead_nxt;
        clr      <= 1'b0;
        if (cmd_valid) begin
          tgt_duty <= cmd_in[COUNT_SIZE-1:0];
          tgt_dir  <= cmd_in[30];
        end
      end
    end
  end

  always_comb begin
    steer_word                   = '0;
    steer_word[31]               = clr;
    steer_word[30]               = dir;
    steer_word[COUNT_SIZE-1:0]   = duty;
    busy                         = (state != HOLD);
    at_target                    = (state == HOLD) && (duty == tgt_duty) && (dir == tgt_dir);
  end
endmodule

// File: tb/tb_steering_ramp_controller.sv
// Randomized bench for steering_ramp_controller (STEP=1 and STEP=3 instances side by side)
// against a per-clock arithmetic model of the slew/brake/dead-time rules.
module tb_steering_ramp_controller;
  localparam int TD = 4;
  localparam int DC = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] cmd_in = '0;
  logic        cmd_valid = 1'b0;
  logic [31:0] sw1, sw3;
  logic        busy1, busy3, at1, at3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  steering_ramp_controller #(.COUNT_SIZE(4), .STEP(1), .TICK_DIV(TD), .DEAD_CYCLES(DC)) dut1 (
    .clk(clk), .reset(reset), .cmd_in(cmd_in), .cmd_valid(cmd_valid),
    .steer_word(sw1), .busy(busy1), .at_target(at1));

  steering_ramp_controller #(.COUNT_SIZE(4), .STEP(3), .TICK_DIV(TD), .DEAD_CYCLES(DC)) dut3 (
    .clk(clk), .reset(reset), .cmd_in(cmd_in), .cmd_valid(cmd_valid),
    .steer_word(sw3), .busy(busy3), .at_target(at3));

  typedef struct {
    int presc; int duty; int dir; int tdu; int tdir; int cnt; int busy; int clr;
  } mdl_t;

  mdl_t m1, m3;
  int   q1[$], q3[$], eq[$];
  int   prev_duty[2], prev_dir[2], zrun[2], toggles[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic mdl_t mzero();
    mdl_t m;
    m = '{0, 0, 0, 0, 0, 0, 0, 0};
    return m;
  endfunction

  // One clock of the rules: mismatched direction means head for zero, wait out
  // the dead time at zero, then flip; matched direction means slew to target.
  function automatic mdl_t mstep(input mdl_t m, input bit v, input logic [31:0] c, input int step);
    mdl_t n = m;
    bit tick = (m.presc == TD - 1);
    n.presc = tick ? 0 : m.presc + 1;
    n.clr = 0;
    if (v && c[31]) begin
      n.duty = 0; n.tdu = 0; n.cnt = 0; n.clr = 1; n.busy = 0;
      return n;
    end
    if (m.dir != m.tdir) begin
      n.busy = 1;
      if (m.duty > 0) begin
        n.cnt = 0;
        if (tick) n.duty = (m.duty > step) ? m.duty - step : 0;
      end else begin
        n.cnt = m.cnt + 1;
        if (n.cnt == DC) begin n.dir = m.tdir; n.cnt = 0; end
      end
    end else begin
      n.cnt = 0;
      n.busy = (m.duty != m.tdu);
      if (tick && m.duty < m.tdu) n.duty = (m.tdu - m.duty > step) ? m.duty + step : m.tdu;
      else if (tick && m.duty > m.tdu) n.duty = (m.duty - m.tdu > step) ? m.duty - step : m.tdu;
    end
    if (v) begin n.tdu = int'(c[3:0]); n.tdir = int'(c[30]); end
    return n;
  endfunction

  function automatic logic [31:0] mword(input mdl_t m);
    logic [31:0] w = '0;
    w[31]  = m.clr[0];
    w[30]  = m.dir[0];
    w[3:0] = m.duty[3:0];
    return w;
  endfunction

  function automatic logic mat(input mdl_t m);
    return (m.busy == 0) && (m.duty == m.tdu) && (m.dir == m.tdir);
  endfunction

  task automatic mon_reset();
    for (int k = 0; k < 2; k++) begin
      prev_duty[k] = 0; prev_dir[k] = 0; zrun[k] = 0; toggles[k] = 0;
    end
  endtask

  // Records duty transitions and checks that every direction flip was preceded
  // by at least DC samples at zero duty.
  task automatic mon(input int k, input logic [31:0] w);
    int d = int'(w[3:0]);
    int r = int'(w[30]);
    if (r != prev_dir[k]) begin
      toggles[k]++;
      chk(k == 0 ? "dead_hold1" : "dead_hold3", 32'(zrun[k] >= DC), 32'd1);
    end
    if (d != prev_duty[k]) begin
      if (k == 0) q1.push_back(d); else q3.push_back(d);
    end
    zrun[k] = (d == 0) ? zrun[k] + 1 : 0;
    prev_duty[k] = d;
    prev_dir[k] = r;
  endtask

  task automatic cyc(input bit v, input logic [31:0] c);
    mdl_t n1, n3;
    cmd_valid = v;
    cmd_in = c;
    n1 = mstep(m1, v, c, 1);
    n3 = mstep(m3, v, c, 3);
    @(posedge clk);
    #1;
    m1 = n1; m3 = n3;
    cmd_valid = 1'b0;
    chk("word1", sw1, mword(m1));
    chk("busy1", 32'(busy1), 32'(m1.busy));
    chk("at1", 32'(at1), 32'(mat(m1)));
    chk("word3", sw3, mword(m3));
    chk("busy3", 32'(busy3), 32'(m3.busy));
    chk("at3", 32'(at3), 32'(mat(m3)));
    mon(0, sw1);
    mon(1, sw3);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0);
  endtask

  task automatic chk_seq(input string tag, input int q[$], input int e[$]);
    chk(tag, 32'(q.size()), 32'(e.size()));
    for (int i = 0; i < e.size() && i < q.size(); i++) chk(tag, 32'(q[i]), 32'(e[i]));
  endtask

  task automatic wait_duty(input string tag, input int k, input int val, input int budget);
    bit found = 0;
    for (int i = 0; i < budget; i++) begin
      if (int'((k == 0 ? sw1 : sw3) & 32'hF) == val) begin found = 1; break; end
      cyc(1'b0, 32'h0);
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  initial begin
    m1 = mzero(); m3 = mzero();
    mon_reset();
    #3;
    chk("rst_word", sw1, 32'h0);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_at", 32'(at1), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    idle(20);
    chk("idle_word", sw1, 32'h0);
    chk("idle_at", 32'(at1), 32'd1);

    q1.delete(); q3.delete();
    cyc(1'b1, 32'h0000_0008);
    idle(40);
    eq = '{1, 2, 3, 4, 5, 6, 7, 8};  chk_seq("ramp8_seq1", q1, eq);
    eq = '{3, 6, 8};                 chk_seq("ramp8_seq3", q3, eq);
    chk("ramp8_at", 32'(at1), 32'd1);
    chk("ramp8_busy", 32'(busy1), 32'd0);

    q1.delete(); q3.delete();
    cyc(1'b1, 32'h4000_0004);
    idle(70);
    eq = '{7, 6, 5, 4, 3, 2, 1, 0, 1, 2, 3, 4};  chk_seq("rev_seq1", q1, eq);
    eq = '{5, 2, 0, 3, 4};                       chk_seq("rev_seq3", q3, eq);
    chk("rev_word", sw1, 32'h4000_0004);

    // Reverse again, then cancel the reversal while the dead time is running.
    q1.delete();
    toggles[0] = 0;
    cyc(1'b1, 32'h0000_0003);
    wait_duty("wait_zero", 0, 0, 40);
    cyc(1'b1, 32'h4000_0002);
    idle(30);
    eq = '{3, 2, 1, 0, 1, 2};  chk_seq("cancel_seq", q1, eq);
    chk("cancel_toggles", 32'(toggles[0]), 32'd0);
    chk("cancel_word", sw1, 32'h4000_0002);

    cyc(1'b1, 32'h4000_000F);
    wait_duty("wait_five", 0, 5, 60);
    cyc(1'b1, 32'h8000_000F);
    chk("clr_pulse", sw1, 32'hC000_0000);
    cyc(1'b0, 32'h0);
    chk("clr_after", sw1, 32'h4000_0000);
    chk("clr_busy", 32'(busy1), 32'd0);

    q3.delete();
    cyc(1'b1, 32'h4000_000E);
    wait_duty("wait_14", 1, 14, 40);
    eq = '{3, 6, 9, 12, 14};  chk_seq("step3_seq", q3, eq);

    #2 reset = 1'b1;
    #1;
    chk("arst_word1", sw1, 32'h0);
    chk("arst_busy1", 32'(busy1), 32'd0);
    chk("arst_word3", sw3, 32'h0);
    chk("arst_at1", 32'(at1), 32'd1);
    m1 = mzero(); m3 = mzero();
    mon_reset();
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 400; i++) begin
      logic [31:0] c;
      bit v;
      v = ($urandom_range(0, 7) == 0);
      c = $urandom;
      c[31] = ($urandom_range(0, 15) == 0);
      cyc(v, c);
    end
    idle(80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
